icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Direct-mapped instruction cache sitting between the CPU fetch stage and the burst controller that fronts instruction memory port 1.
- Serves hits combinationally in the same cycle.
- On a miss, issues a single line-aligned burst request, collects the returned word stream into the data array, then validates the line and resumes.
- Owns all tag and valid state, plus a whole-cache invalidate used by fence.i.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction word width
BLOCK_SIZE, 8, words per line (power of two, >=2)
NUM_LINES, 32, lines in cache (power of two)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
cpu_req  in  1  fetch request, held until cpu_valid
cpu_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
cpu_instr  out  DATA_WIDTH  fetched word, meaningful only when cpu_valid=1
cpu_valid  out  1  hit/return strobe for current cpu_addr
cpu_stall  out  1  cpu_req=1 and cpu_valid=0
invalidate  in  1  single-cycle pulse, clear all valid bits
mem_req  out  1  one-cycle burst request pulse
mem_addr  out  ADDR_WIDTH  line-aligned miss address
mem_burst_len  out  $clog2(BLOCK_SIZE)+1  constant BLOCK_SIZE-1
mem_data  in  DATA_WIDTH  burst word
mem_ready  in  1  burst controller idle / able to accept
mem_valid  in  1  mem_data valid this cycle
mem_last  in  1  final word of burst

Behaviour:
- Address split: offset [1:0]; word index W = $clog2(BLOCK_SIZE) bits above offset; line index I = $clog2(NUM_LINES) bits above W; tag = remaining upper bits.
- Reset (rst=0, asynchronous):
  - All valid bits = 0; state = IDLE; fill counter = 0; inv_pending = 0.
  - Outputs: mem_req=0, mem_addr=0, cpu_valid=0, cpu_stall=0, cpu_instr=0.
  - Tag/data arrays are not reset.
- States: IDLE, REQ, FILL.
- IDLE:
  - Hit = cpu_req & valid[I] & tag[I]==tag(cpu_addr).
  - On hit: cpu_valid=1 and cpu_instr=data[I][W], combinational, zero latency.
  - On miss: capture cpu_addr line-aligned into miss_addr and go to REQ.
  - invalidate=1 in IDLE: clear all valid bits at the clock edge; cpu_valid forced 0 that cycle; no miss is started that cycle.
- REQ:
  - mem_addr=miss_addr. mem_req = mem_ready (combinational); it is never asserted while mem_ready=0.
  - On mem_req&mem_ready: go to FILL with counter=0.
  - mem_req is high for exactly one cycle per miss.
- FILL:
  - Each cycle with mem_valid=1: write mem_data to data[miss I][counter], then counter+1.
  - mem_valid=1 with mem_last=1:
    - If counter==BLOCK_SIZE-1 and inv_pending=0: write tag and set valid.
    - Otherwise leave the line invalid (short burst, or invalidate during the miss).
    - Clear inv_pending and return to IDLE.
  - Words arriving after the counter saturates at BLOCK_SIZE-1 are not written.
- mem_valid outside FILL is ignored.
- invalidate during REQ/FILL: clear all valid bits immediately and set inv_pending. The in-flight line completes its writes but is not validated; the CPU re-misses and refetches.
- cpu_valid is 0 throughout REQ/FILL. The CPU holds cpu_addr; the cache uses only miss_addr during the miss.
- Miss latency with a ready burst controller (2 cycles/word):
  - Miss detected at cycle 0.
  - mem_req at cycle 1.
  - Words at cycles 3,5,...,2*BLOCK_SIZE+1.
  - Hit in IDLE at cycle 2*BLOCK_SIZE+2 (cycle 18 for the default BLOCK_SIZE).
- Reset mid-FILL: the whole cache invalidates and the FSM returns to IDLE; partial data is discarded by validity.

Decomposition:
- cache_pkg holds:
  - localparams OFFSET_BITS, WORD_BITS, INDEX_BITS, TAG_BITS;
  - state encoding IDLE=2'b00, REQ=2'b01, FILL=2'b10;
  - address-field extraction functions.
- One sub-module, icache_data_array: NUM_LINES x BLOCK_SIZE words, one write port (line, word, data, we), one asynchronous read port.
- Tag and valid arrays plus the FSM stay in icache_refill.

Test Plan:
- Cold miss: reset, cpu_req at 0x0000_0040 with a model memory of word=addr.
  - Expect one mem_req pulse at cycle 1 with mem_addr=0x0000_0040 and mem_burst_len=7.
  - Expect cpu_valid at cycle 18 with cpu_instr=0x0000_0040.
- Hit sweep after the fill: cpu_addr 0x44..0x5C.
  - Expect same-cycle cpu_valid and cpu_instr equal to the address.
  - Expect no further mem_req.
- Conflict: fetch 0x0000_0040, then 0x0000_0440 (same index for the defaults, different tag).
  - Expect a refill; then 0x40 misses again and issues mem_req with mem_addr=0x40.
- Invalidate during FILL: pulse invalidate at the 4th mem_valid.
  - Expect the burst to complete but the line to stay invalid, so the held cpu_req misses again and a second mem_req is issued.
- mem_ready low: hold mem_ready=0 for 5 cycles in REQ.
  - Expect mem_req=0 throughout, then a single pulse when ready rises.
- Async reset mid-FILL: drive rst=0 after 3 words.
  - Expect immediate mem_req=0 and cpu_valid=0.
  - After release, the same address misses again.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared configuration, FSM encoding and address-field helpers for the
// direct-mapped instruction cache refill block.
package icache_refill_pkg;

  localparam int ADDR_WIDTH_D = 32;
  localparam int DATA_WIDTH_D = 32;
  localparam int BLOCK_SIZE_D = 8;
  localparam int NUM_LINES_D  = 32;

  localparam int OFFSET_BITS = 2;
  localparam int WORD_BITS   = $clog2(BLOCK_SIZE_D);
  localparam int INDEX_BITS  = $clog2(NUM_LINES_D);
  localparam int TAG_BITS    = ADDR_WIDTH_D - OFFSET_BITS - WORD_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    FILL = 2'b10
  } state_e;

  // Extract `width` bits starting at `lsb`; callers size-cast the result.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (addr >> lsb) & mask;
  endfunction

  function automatic logic [63:0] line_base(input logic [63:0] addr,
                                            input int unsigned lsb);
    return addr & ~((64'd1 << lsb) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Fetch-side and burst-side signal bundle; the cache uses the slave view,
// the CPU/burst-controller environment uses the master view.
interface icache_refill_if
  import icache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int BLOCK_SIZE = BLOCK_SIZE_D
);
  logic                          cpu_req;
  logic [ADDR_WIDTH-1:0]         cpu_addr;
  logic [DATA_WIDTH-1:0]         cpu_instr;
  logic                          cpu_valid;
  logic                          cpu_stall;
  logic                          invalidate;
  logic                          mem_req;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [$clog2(BLOCK_SIZE):0]   mem_burst_len;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic                          mem_ready;
  logic                          mem_valid;
  logic                          mem_last;

  modport slave (
    input  cpu_req, cpu_addr, invalidate, mem_data, mem_ready, mem_valid, mem_last,
    output cpu_instr, cpu_valid, cpu_stall, mem_req, mem_addr, mem_burst_len
  );

  modport master (
    output cpu_req, cpu_addr, invalidate, mem_data, mem_ready, mem_valid, mem_last,
    input  cpu_instr, cpu_valid, cpu_stall, mem_req, mem_addr, mem_burst_len
  );
endinterface

// File: rtl/icache_refill_data_array.sv
// Instruction data storage: one synchronous write port for refill, one
// asynchronous read port so hits return in the request cycle.
module icache_data_array #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int NUM_LINES  = 32
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(NUM_LINES)-1:0]  i_wr_line,
  input  logic [$clog2(BLOCK_SIZE)-1:0] i_wr_word,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(NUM_LINES)-1:0]  i_rd_line,
  input  logic [$clog2(BLOCK_SIZE)-1:0] i_rd_word,
  output logic [DATA_WIDTH-1:0]         o_rd_data
);
  localparam int DEPTH = NUM_LINES * BLOCK_SIZE;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Refill write; contents are deliberately not reset, validity guards them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_wr_line, i_wr_word}] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[{i_rd_line, i_rd_word}];
endmodule

// File: rtl/icache_refill.sv
// Direct-mapped instruction cache: combinational hits, single-burst line
// refill, and whole-cache invalidate for fence.i.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int BLOCK_SIZE = BLOCK_SIZE_D,
  parameter int NUM_LINES  = NUM_LINES_D
) (
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.slave  bus
);
  localparam int L_WB     = $clog2(BLOCK_SIZE);
  localparam int L_IB     = $clog2(NUM_LINES);
  localparam int LINE_LSB = OFFSET_BITS + L_WB;
  localparam int TAG_LSB  = LINE_LSB + L_IB;
  localparam int L_TB     = ADDR_WIDTH - TAG_LSB;
  localparam int BL_W     = L_WB + 1;
  localparam logic [L_WB-1:0] LAST_WORD = L_WB'(BLOCK_SIZE - 1);

  state_e                r_state;
  logic [NUM_LINES-1:0]  r_valid;
  logic [L_TB-1:0]       r_tag [NUM_LINES];
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [L_WB-1:0]       r_cnt;
  logic                  r_sat;
  logic                  r_inv_pending;

  logic [63:0]           w_cpu_addr64;
  logic [63:0]           w_miss_addr64;
  logic [L_WB-1:0]       w_cpu_word;
  logic [L_IB-1:0]       w_cpu_idx;
  logic [L_TB-1:0]       w_cpu_tag;
  logic [L_IB-1:0]       w_miss_idx;
  logic [L_TB-1:0]       w_miss_tag;
  logic                  w_hit;
  logic                  w_mem_req;
  logic                  w_we;
  logic                  w_fill_done;
  logic                  w_fill_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_cpu_addr64  = 64'(bus.cpu_addr);
  assign w_miss_addr64 = 64'(r_miss_addr);
  assign w_cpu_word    = L_WB'(addr_field(w_cpu_addr64, OFFSET_BITS, L_WB));
  assign w_cpu_idx     = L_IB'(addr_field(w_cpu_addr64, LINE_LSB, L_IB));
  assign w_cpu_tag     = L_TB'(addr_field(w_cpu_addr64, TAG_LSB, L_TB));
  assign w_miss_idx    = L_IB'(addr_field(w_miss_addr64, LINE_LSB, L_IB));
  assign w_miss_tag    = L_TB'(addr_field(w_miss_addr64, TAG_LSB, L_TB));

  // Invalidate masks a hit in the same cycle so fence.i never returns stale code.
  assign w_hit = bus.cpu_req & r_valid[w_cpu_idx] & (r_tag[w_cpu_idx] == w_cpu_tag)
               & (r_state == IDLE) & ~bus.invalidate;

  assign w_mem_req   = (r_state == REQ) & bus.mem_ready;
  assign w_we        = (r_state == FILL) & bus.mem_valid & ~r_sat;
  assign w_fill_done = (r_state == FILL) & bus.mem_valid & bus.mem_last;
  assign w_fill_ok   = w_fill_done & (r_cnt == LAST_WORD) & ~r_inv_pending & ~bus.invalidate;

  icache_data_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .NUM_LINES  (NUM_LINES)
  ) u_data (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_line (w_miss_idx),
    .i_wr_word (r_cnt),
    .i_wr_data (bus.mem_data),
    .i_rd_line (w_cpu_idx),
    .i_rd_word (w_cpu_word),
    .o_rd_data (w_rd_data)
  );

  // CPU-facing return path.
  always_comb begin
    bus.cpu_valid = w_hit;
    bus.cpu_stall = rst & bus.cpu_req & ~w_hit;
    bus.cpu_instr = {DATA_WIDTH{1'b0}};
    if (w_hit) begin
      bus.cpu_instr = w_rd_data;
    end else begin
      bus.cpu_instr = {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.mem_req       = w_mem_req;
  assign bus.mem_addr      = r_miss_addr;
  assign bus.mem_burst_len = BL_W'(BLOCK_SIZE - 1);

  // Refill FSM with valid bits and pending-invalidate bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_valid       <= {NUM_LINES{1'b0}};
      r_miss_addr   <= {ADDR_WIDTH{1'b0}};
      r_cnt         <= {L_WB{1'b0}};
      r_sat         <= 1'b0;
      r_inv_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.invalidate && bus.cpu_req && !w_hit) begin
            r_miss_addr <= ADDR_WIDTH'(line_base(w_cpu_addr64, LINE_LSB));
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (w_mem_req) begin
            r_state <= FILL;
            r_cnt   <= {L_WB{1'b0}};
            r_sat   <= 1'b0;
          end
        end
        FILL: begin
          if (bus.mem_valid) begin
            if (r_cnt == LAST_WORD) begin
              r_sat <= 1'b1;
            end else begin
              r_cnt <= r_cnt + L_WB'(1);
            end
            if (bus.mem_last) begin
              r_state       <= IDLE;
              r_inv_pending <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // An invalidate on the closing beat needs no pending flag: the line is already refused.
      if (bus.invalidate) begin
        r_valid <= {NUM_LINES{1'b0}};
        if ((r_state != IDLE) && !w_fill_done) begin
          r_inv_pending <= 1'b1;
        end
      end else if (w_fill_ok) begin
        r_valid[w_miss_idx] <= 1'b1;
      end
    end
  end

  // Tag store, written only when a complete clean line lands.
  always_ff @(posedge clk) begin
    if (w_fill_ok) begin
      r_tag[w_miss_idx] <= w_miss_tag;
    end
  end
endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: reset, cold miss timing, hit table,
// conflict refill, invalidate, mem_ready back-pressure and reset mid-fill.
module tb_icache_refill;
  import icache_refill_pkg::*;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        exp_valid;
    logic        exp_stall;
    logic [31:0] exp_instr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   req_cnt = 0;
  int   r0;
  vec_t vecs [10];

  icache_refill_if bus();

  icache_refill dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) req_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Present a fetch that must miss in the current cycle, then advance to cycle 1.
  task automatic new_miss(input logic [31:0] a);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);
    chk1("miss_cpu_valid", bus.cpu_valid, 1'b0);
    chk1("miss_cpu_stall", bus.cpu_stall, 1'b1);
    chk1("miss_mem_req", bus.mem_req, 1'b0);
    tick();
  endtask

  // Ready burst controller: request seen now, words every other cycle from cycle 3.
  task automatic burst(input logic [31:0] base, input int inv_at, input int rst_at);
    @(negedge clk);
    chk1("mem_req_pulse", bus.mem_req, 1'b1);
    chk32("mem_addr", bus.mem_addr, base);
    chk32("burst_len", 32'(bus.mem_burst_len), 32'd7);
    tick();
    @(negedge clk);
    chk1("mem_req_once", bus.mem_req, 1'b0);
    chk1("fill_stall", bus.cpu_stall, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == rst_at) begin
        rst = 1'b0;
        #1;
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_cpu_valid", bus.cpu_valid, 1'b0);
        chk1("rst_cpu_stall", bus.cpu_stall, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        return;
      end
      bus.mem_valid  = 1'b1;
      bus.mem_data   = base + 32'(4 * i);
      bus.mem_last   = (i == 7);
      bus.invalidate = (i == inv_at);
      @(negedge clk);
      chk1("fill_cpu_valid", bus.cpu_valid, 1'b0);
      tick();
      bus.mem_valid  = 1'b0;
      bus.mem_last   = 1'b0;
      bus.invalidate = 1'b0;
    end
  endtask

  task automatic expect_hit(input string n, input logic [31:0] e);
    @(negedge clk);
    chk1({n, "_valid"}, bus.cpu_valid, 1'b1);
    chk32({n, "_instr"}, bus.cpu_instr, e);
    chk1({n, "_stall"}, bus.cpu_stall, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0044};
    vecs[1] = '{1'b1, 32'h0000_0048, 1'b1, 1'b0, 32'h0000_0048};
    vecs[2] = '{1'b1, 32'h0000_004C, 1'b1, 1'b0, 32'h0000_004C};
    vecs[3] = '{1'b1, 32'h0000_0050, 1'b1, 1'b0, 32'h0000_0050};
    vecs[4] = '{1'b1, 32'h0000_0054, 1'b1, 1'b0, 32'h0000_0054};
    vecs[5] = '{1'b1, 32'h0000_0058, 1'b1, 1'b0, 32'h0000_0058};
    vecs[6] = '{1'b1, 32'h0000_005C, 1'b1, 1'b0, 32'h0000_005C};
    vecs[7] = '{1'b1, 32'h0000_0042, 1'b1, 1'b0, 32'h0000_0040};
    vecs[8] = '{1'b0, 32'h0000_0044, 1'b0, 1'b0, 32'h0000_0000};
    vecs[9] = '{1'b1, 32'h0000_005F, 1'b1, 1'b0, 32'h0000_005C};

    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = 32'h0;
    bus.invalidate = 1'b0;
    bus.mem_data   = 32'h0;
    bus.mem_ready  = 1'b1;
    bus.mem_valid  = 1'b0;
    bus.mem_last   = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    chk1("reset_mem_req", bus.mem_req, 1'b0);
    chk32("reset_mem_addr", bus.mem_addr, 32'h0);
    chk1("reset_cpu_valid", bus.cpu_valid, 1'b0);
    chk1("reset_cpu_stall", bus.cpu_stall, 1'b0);
    chk32("reset_cpu_instr", bus.cpu_instr, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Cold miss: hit lands at cycle 18.
    new_miss(32'h0000_0040);
    burst(32'h0000_0040, -1, -1);
    expect_hit("cold", 32'h0000_0040);

    r0 = req_cnt;
    for (int v = 0; v < 10; v++) begin
      tick();
      bus.cpu_req  = vecs[v].req;
      bus.cpu_addr = vecs[v].addr;
      @(negedge clk);
      chk1("sweep_valid", bus.cpu_valid, vecs[v].exp_valid);
      chk1("sweep_stall", bus.cpu_stall, vecs[v].exp_stall);
      chk1("sweep_mem_req", bus.mem_req, 1'b0);
      if (vecs[v].exp_valid) chk32("sweep_instr", bus.cpu_instr, vecs[v].exp_instr);
    end
    tick();
    chk32("sweep_req_count", 32'(req_cnt - r0), 32'd0);

    // Conflict on index 2.
    new_miss(32'h0000_0440);
    burst(32'h0000_0440, -1, -1);
    expect_hit("conflict_b", 32'h0000_0440);
    tick();
    new_miss(32'h0000_0040);
    burst(32'h0000_0040, -1, -1);
    expect_hit("conflict_a", 32'h0000_0040);
    tick();

    // Invalidate on the 4th returned word.
    new_miss(32'h0000_0080);
    burst(32'h0000_0080, 3, -1);
    @(negedge clk);
    chk1("inv_fill_valid", bus.cpu_valid, 1'b0);
    chk1("inv_fill_stall", bus.cpu_stall, 1'b1);
    tick();
    burst(32'h0000_0080, -1, -1);
    expect_hit("inv_refetch", 32'h0000_0080);
    tick();

    // Back-pressure in REQ for 5 cycles, unaligned word inside the line.
    r0 = req_cnt;
    bus.mem_ready = 1'b0;
    new_miss(32'h0000_00C8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("notready_mem_req", bus.mem_req, 1'b0);
      tick();
    end
    bus.mem_ready = 1'b1;
    burst(32'h0000_00C0, -1, -1);
    expect_hit("notready", 32'h0000_00C8);
    tick();
    chk32("notready_req_count", 32'(req_cnt - r0), 32'd1);

    // Invalidate in IDLE on a hitting address.
    bus.invalidate = 1'b1;
    @(negedge clk);
    chk1("inv_idle_valid", bus.cpu_valid, 1'b0);
    tick();
    bus.invalidate = 1'b0;
    @(negedge clk);
    chk1("inv_idle_no_miss", bus.mem_req, 1'b0);
    chk1("inv_idle_after", bus.cpu_valid, 1'b0);
    tick();
    burst(32'h0000_00C0, -1, -1);
    expect_hit("inv_idle_refetch", 32'h0000_00C8);
    tick();

    // Asynchronous reset after 3 words.
    new_miss(32'h0000_0100);
    burst(32'h0000_0100, -1, 3);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk1("post_rst_valid", bus.cpu_valid, 1'b0);
    chk1("post_rst_mem_req", bus.mem_req, 1'b0);
    tick();
    burst(32'h0000_0100, -1, -1);
    expect_hit("post_rst", 32'h0000_0100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
